// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates entries at issue, captures CDB results,
// retires ready head entries into register_file and raises a one-cycle flush on mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int XLEN           = 32,
    parameter int REG_CNT_WIDTH  = 5,
    parameter int INST_OP_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      stall,
    input  logic                      dec_ready,
    input  logic [INST_OP_WIDTH-1:0]  dec_op,
    input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
    input  logic                      cdb_enable,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_id,
    input  logic [XLEN-1:0]           cdb_val,
    input  logic                      cdb_mispredict,
    input  logic [XLEN-1:0]           cdb_pc,
    input  logic [ROB_SIZE_WIDTH-1:0] qry1_id,
    input  logic [ROB_SIZE_WIDTH-1:0] qry2_id,
    output logic                      qry1_ready,
    output logic [XLEN-1:0]           qry1_val,
    output logic                      qry2_ready,
    output logic [XLEN-1:0]           qry2_val,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
    output logic                      rob_rf_enable,
    output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
    output logic [XLEN-1:0]           rob_rf_val,
    output logic                      rob_store_commit,
    output logic                      rob_flush,
    output logic [XLEN-1:0]           rob_flush_pc
);
    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
    localparam int CW       = ROB_SIZE_WIDTH + 1;

    localparam logic [INST_OP_WIDTH-1:0] OP_BEQ  = INST_OP_WIDTH'(5);
    localparam logic [INST_OP_WIDTH-1:0] OP_BGEU = INST_OP_WIDTH'(10);
    localparam logic [INST_OP_WIDTH-1:0] OP_SB   = INST_OP_WIDTH'(16);
    localparam logic [INST_OP_WIDTH-1:0] OP_SW   = INST_OP_WIDTH'(18);

    logic [ROB_SIZE-1:0]      busy, ready, mis;
    logic [INST_OP_WIDTH-1:0] op_q  [ROB_SIZE];
    logic [REG_CNT_WIDTH-1:0] rd_q  [ROB_SIZE];
    logic [XLEN-1:0]          val_q [ROB_SIZE];
    logic [XLEN-1:0]          pc_q  [ROB_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] head, tail;
    logic [CW-1:0]            count;
    logic                     flush_pending;
    logic [XLEN-1:0]          pending_pc;

    logic blocked, do_issue, do_commit, cdb_hit;
    logic head_store, head_branch, head_writes;

    always_comb begin
        rob_full    = count >= CW'(ROB_SIZE - 1);
        blocked     = flush_pending | rob_flush;
        do_issue    = dec_ready & ~stall & ~rob_full & ~blocked;
        // commit sees only the registered ready bit; the CDB is not bypassed here
        do_commit   = busy[head] & ready[head] & ~blocked;
        cdb_hit     = cdb_enable & busy[cdb_id] & ~rob_flush;
        head_store  = (op_q[head] >= OP_SB) && (op_q[head] <= OP_SW);
        head_branch = (op_q[head] >= OP_BEQ) && (op_q[head] <= OP_BGEU);
        head_writes = ~head_store & ~head_branch & (rd_q[head] != '0);

        qry1_ready  = ready[qry1_id] | (cdb_enable & (cdb_id == qry1_id));
        qry1_val    = ready[qry1_id] ? val_q[qry1_id] : cdb_val;
        qry2_ready  = ready[qry2_id] | (cdb_enable & (cdb_id == qry2_id));
        qry2_val    = ready[qry2_id] ? val_q[qry2_id] : cdb_val;
        rob_head_id = head;
        rob_tail_id = tail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0; ready <= '0; mis <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                op_q[i] <= '0; rd_q[i] <= '0; val_q[i] <= '0; pc_q[i] <= '0;
            end
            head <= '0; tail <= '0; count <= '0;
            flush_pending <= 1'b0; pending_pc <= '0;
            rob_rf_enable <= 1'b0; rob_rf_rd <= '0; rob_rf_val <= '0;
            rob_store_commit <= 1'b0; rob_flush <= 1'b0; rob_flush_pc <= '0;
        end else if (rdy) begin
            if (flush_pending) begin
                busy <= '0; ready <= '0; mis <= '0;
                head <= '0; tail <= '0; count <= '0;
                flush_pending    <= 1'b0;
                rob_flush        <= 1'b1;
                rob_flush_pc     <= pending_pc;
                rob_rf_enable    <= 1'b0;
                rob_store_commit <= 1'b0;
            end else begin
                rob_flush <= 1'b0;
                if (cdb_hit) begin
                    ready[cdb_id] <= 1'b1;
                    val_q[cdb_id] <= cdb_val;
                    mis[cdb_id]   <= cdb_mispredict;
                    pc_q[cdb_id]  <= cdb_pc;
                end
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    mis[tail]   <= 1'b0;
                    op_q[tail]  <= dec_op;
                    rd_q[tail]  <= dec_rd;
                    tail        <= tail + ROB_SIZE_WIDTH'(1);
                end
                rob_rf_enable    <= do_commit & head_writes;
                rob_store_commit <= do_commit & head_store;
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + ROB_SIZE_WIDTH'(1);
                    rob_rf_rd  <= rd_q[head];
                    rob_rf_val <= val_q[head];
                    if (mis[head]) begin
                        flush_pending <= 1'b1;
                        pending_pc    <= pc_q[head];
                    end
                end
                count <= count + CW'(do_issue) - CW'(do_commit);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a cycle table covering issue/complete/commit/flush,
// plus hand sequences for full, wraparound, query bypass, rdy freeze and async reset.
module tb_reorder_buffer;
    localparam logic [5:0] JALR = 6'd4, BEQ = 6'd5, SW = 6'd18, ADDI = 6'd19, ADD = 6'd28;

    logic        clk, rst, rdy, stall, dec_ready;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd;
    logic        cdb_enable, cdb_mispredict;
    logic [2:0]  cdb_id, qry1_id, qry2_id;
    logic [31:0] cdb_val, cdb_pc;
    logic        qry1_ready, qry2_ready, rob_full;
    logic [31:0] qry1_val, qry2_val, rob_rf_val, rob_flush_pc;
    logic [2:0]  rob_head_id, rob_tail_id;
    logic        rob_rf_enable, rob_store_commit, rob_flush;
    logic [4:0]  rob_rf_rd;

    int pass_cnt = 0;
    int total_cnt = 0;

    reorder_buffer #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5), .INST_OP_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .dec_ready(dec_ready),
        .dec_op(dec_op), .dec_rd(dec_rd), .cdb_enable(cdb_enable), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .cdb_mispredict(cdb_mispredict), .cdb_pc(cdb_pc),
        .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready), .qry1_val(qry1_val),
        .qry2_ready(qry2_ready), .qry2_val(qry2_val), .rob_full(rob_full),
        .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id), .rob_rf_enable(rob_rf_enable),
        .rob_rf_rd(rob_rf_rd), .rob_rf_val(rob_rf_val), .rob_store_commit(rob_store_commit),
        .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dr;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        ce;
        logic [2:0]  cid;
        logic [31:0] cval;
        logic        cmis;
        logic [31:0] cpc;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_st;
        logic        e_fl;
        logic [31:0] e_fpc;
        logic [2:0]  e_head;
        logic [2:0]  e_tail;
    } vec_t;

    vec_t vt[25];

    function automatic vec_t mk(logic dr, logic [5:0] op, logic [4:0] rd, logic ce, logic [2:0] cid,
                                logic [31:0] cval, logic cmis, logic [31:0] cpc, logic e_en,
                                logic [4:0] e_rd, logic [31:0] e_val, logic e_st, logic e_fl,
                                logic [31:0] e_fpc, logic [2:0] e_head, logic [2:0] e_tail);
        vec_t v;
        v.dr = dr; v.op = op; v.rd = rd; v.ce = ce; v.cid = cid; v.cval = cval;
        v.cmis = cmis; v.cpc = cpc; v.e_en = e_en; v.e_rd = e_rd; v.e_val = e_val;
        v.e_st = e_st; v.e_fl = e_fl; v.e_fpc = e_fpc; v.e_head = e_head; v.e_tail = e_tail;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_ready = 0; dec_op = '0; dec_rd = '0;
        cdb_enable = 0; cdb_id = '0; cdb_val = '0; cdb_mispredict = 0; cdb_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        rdy = 1; stall = 0; qry1_id = '0; qry2_id = '0;
        do_reset();
        check("reset_head", 32'(rob_head_id), 0);
        check("reset_tail", 32'(rob_tail_id), 0);
        check("reset_rf_en", 32'(rob_rf_enable), 0);
        check("reset_full", 32'(rob_full), 0);
        check("reset_flush", 32'(rob_flush), 0);

        //                dr op    rd  ce id val         mis pc     en rd val        st fl fpc    h  t
        vt[0]  = mk(1, ADD,  5, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     0, 1);
        vt[1]  = mk(0, 0,    0, 1, 0, 32'h1234,   0, 0,     0, 0, 0,          0, 0, 0,     0, 1);
        vt[2]  = mk(0, 0,    0, 0, 0, 0,          0, 0,     1, 5, 32'h1234,   0, 0, 0,     1, 1);
        vt[3]  = mk(1, ADDI, 6, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     1, 2);
        vt[4]  = mk(1, ADD,  7, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     1, 3);
        vt[5]  = mk(0, 0,    0, 1, 2, 32'hBBBB,   0, 0,     0, 0, 0,          0, 0, 0,     1, 3);
        vt[6]  = mk(0, 0,    0, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     1, 3);
        vt[7]  = mk(0, 0,    0, 1, 1, 32'hAAAA,   0, 0,     0, 0, 0,          0, 0, 0,     1, 3);
        vt[8]  = mk(0, 0,    0, 0, 0, 0,          0, 0,     1, 6, 32'hAAAA,   0, 0, 0,     2, 3);
        vt[9]  = mk(0, 0,    0, 0, 0, 0,          0, 0,     1, 7, 32'hBBBB,   0, 0, 0,     3, 3);
        vt[10] = mk(1, SW,   9, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     3, 4);
        vt[11] = mk(0, 0,    0, 1, 3, 0,          0, 0,     0, 0, 0,          0, 0, 0,     3, 4);
        vt[12] = mk(0, 0,    0, 0, 0, 0,          0, 0,     0, 0, 0,          1, 0, 0,     4, 4);
        vt[13] = mk(1, ADD,  0, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     4, 5);
        vt[14] = mk(0, 0,    0, 1, 4, 5,          0, 0,     0, 0, 0,          0, 0, 0,     4, 5);
        vt[15] = mk(0, 0,    0, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     5, 5);
        vt[16] = mk(1, BEQ,  3, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     5, 6);
        vt[17] = mk(0, 0,    0, 1, 5, 1,          0, 0,     0, 0, 0,          0, 0, 0,     5, 6);
        vt[18] = mk(0, 0,    0, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     6, 6);
        vt[19] = mk(1, JALR, 1, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     6, 7);
        vt[20] = mk(0, 0,    0, 1, 6, 32'h44,     1, 32'h80, 0, 0, 0,         0, 0, 0,     6, 7);
        vt[21] = mk(0, 0,    0, 0, 0, 0,          0, 0,     1, 1, 32'h44,     0, 0, 0,     7, 7);
        vt[22] = mk(1, ADD,  3, 0, 0, 0,          0, 0,     0, 0, 0,          0, 1, 32'h80, 0, 0);
        vt[23] = mk(1, ADD,  3, 1, 0, 9,          0, 0,     0, 0, 0,          0, 0, 0,     0, 0);
        vt[24] = mk(1, ADD,  3, 0, 0, 0,          0, 0,     0, 0, 0,          0, 0, 0,     0, 1);

        for (int i = 0; i < 25; i++) begin
            dec_ready = vt[i].dr; dec_op = vt[i].op; dec_rd = vt[i].rd;
            cdb_enable = vt[i].ce; cdb_id = vt[i].cid; cdb_val = vt[i].cval;
            cdb_mispredict = vt[i].cmis; cdb_pc = vt[i].cpc;
            step();
            check($sformatf("v%0d_head", i), 32'(rob_head_id), 32'(vt[i].e_head));
            check($sformatf("v%0d_tail", i), 32'(rob_tail_id), 32'(vt[i].e_tail));
            check($sformatf("v%0d_rf_en", i), 32'(rob_rf_enable), 32'(vt[i].e_en));
            check($sformatf("v%0d_store", i), 32'(rob_store_commit), 32'(vt[i].e_st));
            check($sformatf("v%0d_flush", i), 32'(rob_flush), 32'(vt[i].e_fl));
            if (vt[i].e_en) begin
                check($sformatf("v%0d_rf_rd", i), 32'(rob_rf_rd), 32'(vt[i].e_rd));
                check($sformatf("v%0d_rf_val", i), rob_rf_val, vt[i].e_val);
            end
            if (vt[i].e_fl) check($sformatf("v%0d_flush_pc", i), rob_flush_pc, vt[i].e_fpc);
        end

        // full: 7 issues fill, 8th ignored, then commit+issue in one cycle keeps count
        do_reset();
        dec_ready = 1; dec_op = ADD; dec_rd = 2;
        repeat (6) step();
        check("full_at6", 32'(rob_full), 0);
        step();
        check("full_at7", 32'(rob_full), 1);
        check("full_tail7", 32'(rob_tail_id), 7);
        step();
        check("full_ignored_tail", 32'(rob_tail_id), 7);
        cdb_enable = 1; cdb_id = 0; cdb_val = 32'h10;
        step();
        check("full_no_commit_yet", 32'(rob_head_id), 0);
        cdb_id = 1; cdb_val = 32'h11;
        step();
        check("full_commit0_head", 32'(rob_head_id), 1);
        check("full_commit0_val", rob_rf_val, 32'h10);
        check("full_commit0_tail", 32'(rob_tail_id), 7);
        check("full_freed", 32'(rob_full), 0);
        cdb_enable = 0;
        step();
        check("both_head", 32'(rob_head_id), 2);
        check("both_tail", 32'(rob_tail_id), 0);
        check("both_full", 32'(rob_full), 0);
        step();
        check("refill_tail", 32'(rob_tail_id), 1);
        check("refill_full", 32'(rob_full), 1);

        // wraparound: 10 ops issued, completed and retired one at a time
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            dec_ready = 1; dec_op = ADD; dec_rd = 5'(i + 1);
            qry1_id = 3'(i % 8);
            step();
            check($sformatf("wrap%0d_tail", i), 32'(rob_tail_id), 32'((i + 1) % 8));
            check($sformatf("wrap%0d_fresh", i), 32'(qry1_ready), 0);
            dec_ready = 0;
            cdb_enable = 1; cdb_id = 3'(i % 8); cdb_val = 32'h100 + 32'(i);
            qry2_id = 3'(i % 8);
            #1;
            check($sformatf("wrap%0d_bypass_rdy", i), 32'(qry2_ready), 1);
            check($sformatf("wrap%0d_bypass_val", i), qry2_val, 32'h100 + 32'(i));
            step();
            cdb_enable = 0;
            #1;
            check($sformatf("wrap%0d_qry_val", i), qry1_val, 32'h100 + 32'(i));
            step();
            check($sformatf("wrap%0d_rf_en", i), 32'(rob_rf_enable), 1);
            check($sformatf("wrap%0d_rf_rd", i), 32'(rob_rf_rd), 32'(i + 1));
            check($sformatf("wrap%0d_head", i), 32'(rob_head_id), 32'((i + 1) % 8));
        end
        rdy = 0;
        step();
        check("freeze_rf_en", 32'(rob_rf_enable), 1);
        check("freeze_head", 32'(rob_head_id), 2);
        rdy = 1;
        step();
        check("unfreeze_rf_en", 32'(rob_rf_enable), 0);

        // stall blocks issue
        stall = 1; dec_ready = 1; dec_op = ADD; dec_rd = 4;
        step();
        check("stall_tail", 32'(rob_tail_id), 2);
        stall = 0;
        step();
        check("unstall_tail", 32'(rob_tail_id), 3);

        // asynchronous reset mid-cycle
        dec_ready = 1;
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_head", 32'(rob_head_id), 0);
        check("arst_tail", 32'(rob_tail_id), 0);
        check("arst_rf_en", 32'(rob_rf_enable), 0);
        check("arst_rf_val", rob_rf_val, 0);
        check("arst_full", 32'(rob_full), 0);
        idle_inputs();
        step();
        rst = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
